// File: rtl/int_controller.sv
// Interrupt controller: latches rising edges on the IRQ lines, applies the
// mask and global enable, picks the lowest-index eligible source, runs the
// int_req/int_ack handshake with the PC/flag save unit and holds the
// in-service state until RETI.
module int_controller #(
  parameter int                 d_width     = 12,
  parameter int                 ID_W        = 2,
  parameter int                 N_IRQ       = 4,
  parameter logic [d_width-1:0] VEC_BASE    = 12'hF00,
  parameter int                 ACK_TIMEOUT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   irq_in,
  input  logic               mask_wr,
  input  logic [N_IRQ-1:0]   mask_data,
  input  logic               gie_set,
  input  logic               gie_clr,
  input  logic               int_ack,
  input  logic               reti_signal,
  output logic               int_req,
  output logic               int_en,
  output logic [d_width-1:0] int_vector,
  output logic [ID_W-1:0]    int_id,
  output logic               int_active,
  output logic [N_IRQ-1:0]   int_pending,
  output logic               int_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, SERVICE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] irq_prev;
  logic             gie;

  logic [N_IRQ-1:0] edges;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]  winner;
  logic             any_eligible;

  assign int_pending = pending;

  // Edge detection, eligibility, lowest-index priority and the accept-clear mask
  always_comb begin
    edges        = irq_in & ~irq_prev;
    eligible     = pending & mask;
    any_eligible = |eligible;
    winner       = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
    ack_clr = '0;
    if (state == WAIT_ACK && int_ack) ack_clr[int_id] = 1'b1;
  end

  // Pending latches (a new edge beats a coincident clear), mask and global enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
      gie      <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~ack_clr) | edges;
      if (mask_wr) mask <= mask_data;
      if (gie_clr)      gie <= 1'b0;
      else if (gie_set) gie <= 1'b1;
    end
  end

  // Sequencer: select, one-cycle save request, bounded wait for ack, service until RETI
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      int_req     <= 1'b0;
      int_en      <= 1'b0;
      int_vector  <= '0;
      int_id      <= '0;
      int_active  <= 1'b0;
      int_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          int_timeout <= 1'b0;
          if (gie && any_eligible) begin
            state      <= REQ;
            int_id     <= winner;
            int_vector <= VEC_BASE + (d_width'(winner) << 2);
            int_req    <= 1'b1;
            int_en     <= 1'b1;
          end
        end
        REQ: begin
          state   <= WAIT_ACK;
          int_req <= 1'b0;
          int_en  <= 1'b0;
          cnt     <= '0;
        end
        WAIT_ACK: begin
          if (int_ack) begin
            state      <= SERVICE;
            int_active <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            int_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SERVICE: begin
          if (reti_signal) begin
            state      <= IDLE;
            int_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: reset, basic handshake, priority,
// masking/global enable, ack timeout, no nesting and reset mid-sequence.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_data = '0;
  logic        gie_set = 1'b0;
  logic        gie_clr = 1'b0;
  logic        int_ack = 1'b0;
  logic        reti_signal = 1'b0;
  logic        int_req;
  logic        int_en;
  logic [11:0] int_vector;
  logic [1:0]  int_id;
  logic        int_active;
  logic [3:0]  int_pending;
  logic        int_timeout;

  int n_cmp = 0;
  int n_fail = 0;

  int_controller #(
    .d_width(12), .ID_W(2), .N_IRQ(4), .VEC_BASE(12'hF00), .ACK_TIMEOUT(3)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .gie_set(gie_set), .gie_clr(gie_clr),
    .int_ack(int_ack), .reti_signal(reti_signal), .int_req(int_req),
    .int_en(int_en), .int_vector(int_vector), .int_id(int_id),
    .int_active(int_active), .int_pending(int_pending),
    .int_timeout(int_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({int_req, int_en, int_active, int_timeout, int_pending, int_id, int_vector} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b en=%b act=%b to=%b pend=%b id=%0d vec=%h, want all 0",
               int_req, int_en, int_active, int_timeout, int_pending, int_id, int_vector);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    mask_wr = 1'b1; mask_data = 4'b0001; gie_set = 1'b1;
    tick();
    mask_wr = 1'b0; gie_set = 1'b0;
    irq_in = 4'b0001;
    tick();
    n_cmp++;
    if (int_pending !== 4'b0001 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_pending: pend=%b req=%b, want 0001 0", int_pending, int_req);
    end
    tick();
    n_cmp++;
    if ({int_req, int_en, int_vector, int_id} !== {1'b1, 1'b1, 12'hF00, 2'd0}) begin
      n_fail++; $display("FAIL basic_req: req=%b en=%b vec=%h id=%0d, want 1 1 f00 0", int_req, int_en, int_vector, int_id);
    end
    tick();
    n_cmp++;
    if (int_req !== 1'b0 || int_en !== 1'b0 || int_active !== 1'b0) begin
      n_fail++; $display("FAIL basic_req_pulse: req=%b en=%b act=%b, want 0 0 0", int_req, int_en, int_active);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0000;
    n_cmp++;
    if (int_active !== 1'b1 || int_pending !== 4'b0000) begin
      n_fail++; $display("FAIL basic_service: act=%b pend=%b, want 1 0000", int_active, int_pending);
    end
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    n_cmp++;
    if (int_active !== 1'b0 || int_vector !== 12'hF00) begin
      n_fail++; $display("FAIL basic_reti: act=%b vec=%h, want 0 f00", int_active, int_vector);
    end
  endtask

  task automatic test_priority();
    mask_wr = 1'b1; mask_data = 4'hF;
    tick();
    mask_wr = 1'b0;
    irq_in = 4'b1010;
    tick();
    n_cmp++;
    if (int_pending !== 4'b1010) begin
      n_fail++; $display("FAIL prio_pending: pend=%b, want 1010", int_pending);
    end
    tick();
    n_cmp++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd1, 12'hF04}) begin
      n_fail++; $display("FAIL prio_first: req=%b id=%0d vec=%h, want 1 1 f04", int_req, int_id, int_vector);
    end
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    n_cmp++;
    if (int_pending !== 4'b1000 || int_active !== 1'b1) begin
      n_fail++; $display("FAIL prio_clear: pend=%b act=%b, want 1000 1", int_pending, int_active);
    end
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0 || int_active !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle_gap: req=%b act=%b, want 0 0", int_req, int_active);
    end
    tick();
    n_cmp++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd3, 12'hF0C}) begin
      n_fail++; $display("FAIL prio_second: req=%b id=%0d vec=%h, want 1 3 f0c", int_req, int_id, int_vector);
    end
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0000;
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    n_cmp++;
    if (int_pending !== 4'b0000 || int_active !== 1'b0) begin
      n_fail++; $display("FAIL prio_done: pend=%b act=%b, want 0000 0", int_pending, int_active);
    end
  endtask

  task automatic test_mask_gie();
    int reqs;
    gie_clr = 1'b1;
    tick();
    gie_clr = 1'b0;
    irq_in = 4'b0100;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int_req === 1'b1) reqs++;
    end
    n_cmp++;
    if (int_pending !== 4'b0100 || reqs != 0) begin
      n_fail++; $display("FAIL gie_off: pend=%b reqs=%0d, want 0100 0", int_pending, reqs);
    end
    gie_set = 1'b1;
    tick();
    gie_set = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0) begin
      n_fail++; $display("FAIL gie_set_early: req=%b, want 0", int_req);
    end
    tick();
    n_cmp++;
    if ({int_req, int_id, int_vector} !== {1'b1, 2'd2, 12'hF08}) begin
      n_fail++; $display("FAIL gie_set_req: req=%b id=%0d vec=%h, want 1 2 f08", int_req, int_id, int_vector);
    end
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0000;
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    // both strobes together: gie must end up cleared
    gie_set = 1'b1; gie_clr = 1'b1;
    tick();
    gie_set = 1'b0; gie_clr = 1'b0;
    irq_in = 4'b0001;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (int_req === 1'b1) reqs++;
    end
    irq_in = 4'b0000;
    n_cmp++;
    if (int_pending !== 4'b0001 || reqs != 0) begin
      n_fail++; $display("FAIL gie_both: pend=%b reqs=%0d, want 0001 0", int_pending, reqs);
    end
  endtask

  task automatic test_timeout();
    int tos;
    gie_set = 1'b1;
    tick();
    gie_set = 1'b0;
    tick();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      n_fail++; $display("FAIL to_req: req=%b id=%0d, want 1 0", int_req, int_id);
    end
    tos = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int_timeout === 1'b1) tos++;
    end
    n_cmp++;
    if (tos != 0) begin
      n_fail++; $display("FAIL to_early: pulses=%0d, want 0", tos);
    end
    tick();
    n_cmp++;
    if ({int_timeout, int_req, int_active, int_pending} !== {1'b1, 1'b0, 1'b0, 4'b0001}) begin
      n_fail++; $display("FAIL to_pulse: to=%b req=%b act=%b pend=%b, want 1 0 0 0001",
                         int_timeout, int_req, int_active, int_pending);
    end
    tick();
    n_cmp++;
    if (int_timeout !== 1'b0 || int_req !== 1'b1) begin
      n_fail++; $display("FAIL to_retry: to=%b req=%b, want 0 1", int_timeout, int_req);
    end
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    n_cmp++;
    if (int_active !== 1'b1 || int_pending !== 4'b0000) begin
      n_fail++; $display("FAIL to_ack: act=%b pend=%b, want 1 0000", int_active, int_pending);
    end
  endtask

  task automatic test_no_nesting();
    int reqs;
    irq_in = 4'b0001;
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int_req === 1'b1) reqs++;
    end
    n_cmp++;
    if (int_pending !== 4'b0001 || int_active !== 1'b1 || reqs != 0) begin
      n_fail++; $display("FAIL nest_block: pend=%b act=%b reqs=%0d, want 0001 1 0", int_pending, int_active, reqs);
    end
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    tick();
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      n_fail++; $display("FAIL nest_after_reti: req=%b id=%0d, want 1 0", int_req, int_id);
    end
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 4'b0000;
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    // stray handshake strobes while idle
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    reti_signal = 1'b1;
    tick();
    reti_signal = 1'b0;
    tick();
    n_cmp++;
    if ({int_req, int_active, int_timeout, int_pending} !== 7'd0) begin
      n_fail++; $display("FAIL stray_idle: req=%b act=%b to=%b pend=%b, want 0 0 0 0000",
                         int_req, int_active, int_timeout, int_pending);
    end
  endtask

  task automatic test_reset_mid();
    int reqs;
    irq_in = 4'b0100;
    tick();
    tick();
    tick();
    n_cmp++;
    if (int_req !== 1'b0 || int_id !== 2'd2 || int_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_setup: req=%b id=%0d act=%b, want 0 2 0", int_req, int_id, int_active);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({int_req, int_en, int_active, int_timeout, int_pending, int_id, int_vector} !== 22'd0) begin
      n_fail++; $display("FAIL rst_async: req=%b en=%b act=%b to=%b pend=%b id=%0d vec=%h, want all 0",
                         int_req, int_en, int_active, int_timeout, int_pending, int_id, int_vector);
    end
    irq_in = 4'b0010;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (int_pending !== 4'b0010) begin
      n_fail++; $display("FAIL rst_release_edge: pend=%b, want 0010", int_pending);
    end
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int_req === 1'b1) reqs++;
    end
    n_cmp++;
    if (reqs != 0 || int_pending !== 4'b0010) begin
      n_fail++; $display("FAIL rst_masked: reqs=%0d pend=%b, want 0 0010", reqs, int_pending);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_gie();
    test_timeout();
    test_no_nesting();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller that sequences the PC/flag save unit (int_req/int_en/int_ack handshake) and the RETI path.
- Latches rising edges on N_IRQ request lines, applies a mask register and a global enable, and selects the highest-priority eligible source.
- Issues a single-cycle save request and waits for the save unit's acknowledge, then holds the vector and in-service state until RETI.
- Sits between peripheral IRQ lines and the core's interrupt save unit and fetch logic.

Parameters:
- d_width, 12, PC/vector width.
- ID_W, 2, source-index width.
- N_IRQ, 4, number of sources; must equal 2**ID_W.
- VEC_BASE, 12'hF00, vector base address.
- ACK_TIMEOUT, 3, WAIT_ACK cycles allowed before abort (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- irq_in  in  N_IRQ  request lines, level in; rising edge = event.
- mask_wr  in  1  load mask register from mask_data.
- mask_data  in  N_IRQ  new mask; 1 = source enabled.
- gie_set  in  1  set global interrupt enable.
- gie_clr  in  1  clear global interrupt enable.
- int_ack  in  1  save unit has captured PC/C/Z.
- reti_signal  in  1  return-from-interrupt executed.
- int_req  out  1  single-cycle save request to save unit.
- int_en  out  1  save enable to save unit; high only alongside int_req.
- int_vector  out  d_width  handler address of selected source.
- int_id  out  ID_W  index of selected source.
- int_active  out  1  handler in service.
- int_pending  out  N_IRQ  pending latches, masked or not.
- int_timeout  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset, asynchronous: all outputs 0, mask=0, gie=0, pending=0, irq_prev=0, state IDLE, timeout counter 0. A line already high at reset release counts as a rising edge on the first clock.
- Edge detect: pending[i] sets on irq_in[i] & ~irq_prev[i]. Clears only when source i is accepted. If set and clear coincide on the same bit, set wins.
- Mask/GIE:
  - mask_wr loads mask_data on the next edge.
  - gie_set/gie_clr take effect on the next edge; if both are asserted, clr wins.
  - Masked sources still latch pending.
- eligible = pending & mask. Priority: lowest index wins.
- FSM states:
  - IDLE: if gie & |eligible, go to REQ. Register int_id = winner and int_vector = VEC_BASE + (winner<<2), truncated mod 2**d_width. Otherwise stay.
  - REQ (exactly 1 cycle): int_req=1, int_en=1. Go to WAIT_ACK with counter=0.
  - WAIT_ACK: int_req=0, int_en=0.
    - If int_ack: clear pending[int_id], go to SERVICE.
    - Else if counter==ACK_TIMEOUT-1: pulse int_timeout, go to IDLE; pending is kept, so the request is retried.
    - Else counter+1.
  - SERVICE: int_active=1. On reti_signal go to IDLE; int_active falls the next cycle. New edges keep latching pending. No nesting.
- int_ack outside WAIT_ACK is ignored. reti_signal outside SERVICE is ignored.
- gie_clr during REQ/WAIT_ACK/SERVICE does not abort the sequence. It only blocks the next IDLE->REQ.
- int_id and int_vector hold their value until the next IDLE->REQ selection.
- Minimum spacing: at least 1 IDLE cycle between reti_signal and the next int_req.
- Latency: edge on irq_in at clock n (mask and gie set) gives pending at n+1, REQ state (int_req high) at n+2.

Test Plan:
- Basic: mask=4'b0001, gie=1, rising edge on irq_in[0] → pending[0]=1, then int_req/int_en 1-cycle pulse, int_vector=12'hF00, int_id=0. Ack the following cycle → int_active=1, pending[0]=0. reti_signal → int_active=0.
- Priority: edges on irq_in[3] and irq_in[1] in the same cycle, mask=4'hF → id 1 served first (vector 12'hF04). After RETI and one IDLE cycle, id 3 is served (vector 12'hF0C).
- Masking/GIE: gie=0 with mask=4'hF, edge on irq_in[2] → pending=4'b0100, no int_req. gie_set → int_req two cycles later. gie_set and gie_clr together → gie stays 0.
- Timeout: int_ack never driven with ACK_TIMEOUT=3 → int_timeout pulse 3 cycles after REQ, return to IDLE, pending kept, int_req re-issued.
- No nesting: in SERVICE, edge on irq_in[0] → pending[0]=1 but no int_req until after reti_signal. Stray int_ack and reti_signal in IDLE cause no state change.
- Reset mid-operation: assert reset in WAIT_ACK → all outputs 0 immediately. Release with irq_in[1] held high, mask=0 → pending[1]=1 after first clock.
